// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: bundles the MEM->WB pipeline signals.
//   master : upstream MEM stage / hazard unit (drives stall, flush, MEM results)
//   slave  : the MEM/WB stage (drives the registered WB-side outputs)
// Signals:
//   stall, flush, valid_in        - pipeline control from the hazard unit
//   mem_read_data, alu_result     - full aligned memory word and ALU result/address
//   alu_code, mem_to_reg_in       - load width decode and write-back source select
//   reg_write_in, write_reg_in    - register-file write request and destination
//   wb_data, wb_reg, wb_reg_write - registered write-back to the register file
//   valid_out, misalign_err       - WB slot occupancy and sticky misaligned-load flag
//   retire_count                  - accepted-instruction counter
interface mem_wb_stage_if #(
    parameter int DATA_W = 32
);
    logic              stall;
    logic              flush;
    logic              valid_in;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] alu_result;
    logic [4:0]        alu_code;
    logic              mem_to_reg_in;
    logic              reg_write_in;
    logic [4:0]        write_reg_in;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_reg;
    logic              wb_reg_write;
    logic              valid_out;
    logic              misalign_err;
    logic [31:0]       retire_count;

    modport master (
        output stall, flush, valid_in, mem_read_data, alu_result, alu_code,
               mem_to_reg_in, reg_write_in, write_reg_in,
        input  wb_data, wb_reg, wb_reg_write, valid_out, misalign_err, retire_count
    );

    modport slave (
        input  stall, flush, valid_in, mem_read_data, alu_result, alu_code,
               mem_to_reg_in, reg_write_in, write_reg_in,
        output wb_data, wb_reg, wb_reg_write, valid_out, misalign_err, retire_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register.
// Extracts and sign-extends lb/lh loads from the aligned memory word, selects
// load data or ALU result, and registers the write-back value, destination and
// write enable. Supports stall (hold) and flush (bubble, overrides stall),
// flags misaligned loads with a sticky error bit and counts accepted
// instructions.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears every output
//   bus   - mem_wb_stage_if.slave, MEM-side inputs and WB-side outputs
module mem_wb_stage #(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_wb_stage_if.slave  bus
);
    localparam logic [4:0] CODE_LH = 5'b00111;
    localparam logic [4:0] CODE_LB = 5'b01000;

    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_reg_q, wb_reg_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              valid_q, valid_d;
    logic              misalign_err_q, misalign_err_d;
    logic [31:0]       retire_count_q, retire_count_d;

    logic [1:0]        addr;
    logic              is_lh, is_lb;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_data;
    logic              misaligned;
    logic [DATA_W-1:0] next_data;
    logic              next_we;
    logic              accept;

    // Load extraction and next-value computation, all on the raw inputs.
    always_comb begin
        addr  = bus.alu_result[1:0];
        is_lh = (bus.alu_code == CODE_LH);
        is_lb = (bus.alu_code == CODE_LB);

        // little-endian byte lanes
        case (addr)
            2'd0:    byte_sel = bus.mem_read_data[7:0];
            2'd1:    byte_sel = bus.mem_read_data[15:8];
            2'd2:    byte_sel = bus.mem_read_data[23:16];
            default: byte_sel = bus.mem_read_data[31:24];
        endcase
        half_sel = addr[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

        if (is_lb)      load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
        else if (is_lh) load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
        else            load_data = bus.mem_read_data;

        // lb can never be misaligned; anything not lb/lh is treated as lw
        if (!bus.mem_to_reg_in) misaligned = 1'b0;
        else if (is_lb)         misaligned = 1'b0;
        else if (is_lh)         misaligned = addr[0];
        else                    misaligned = (addr != 2'd0);

        // a misaligned load keeps the raw word so the trap handler can see it
        if (!bus.mem_to_reg_in) next_data = bus.alu_result;
        else if (misaligned)    next_data = bus.mem_read_data;
        else                    next_data = load_data;

        next_we = bus.valid_in & bus.reg_write_in & (bus.write_reg_in != 5'd0) & ~misaligned;
        accept  = bus.valid_in & ~bus.flush & ~bus.stall;
    end

    // Update rule: flush beats stall; stall holds everything including the counter.
    always_comb begin
        wb_data_d      = wb_data_q;
        wb_reg_d       = wb_reg_q;
        wb_reg_write_d = wb_reg_write_q;
        valid_d        = valid_q;
        misalign_err_d = misalign_err_q;
        retire_count_d = retire_count_q;
        if (bus.flush) begin
            wb_data_d      = '0;
            wb_reg_d       = '0;
            wb_reg_write_d = 1'b0;
            valid_d        = 1'b0;
        end else if (!bus.stall) begin
            wb_data_d      = next_data;
            wb_reg_d       = bus.write_reg_in;
            wb_reg_write_d = next_we;
            valid_d        = bus.valid_in;
            misalign_err_d = misalign_err_q | (accept & misaligned);
            retire_count_d = retire_count_q + {31'd0, accept};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_q      <= '0;
            wb_reg_q       <= '0;
            wb_reg_write_q <= 1'b0;
            valid_q        <= 1'b0;
            misalign_err_q <= 1'b0;
            retire_count_q <= '0;
        end else begin
            wb_data_q      <= wb_data_d;
            wb_reg_q       <= wb_reg_d;
            wb_reg_write_q <= wb_reg_write_d;
            valid_q        <= valid_d;
            misalign_err_q <= misalign_err_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign bus.wb_data      = wb_data_q;
    assign bus.wb_reg       = wb_reg_q;
    assign bus.wb_reg_write = wb_reg_write_q;
    assign bus.valid_out    = valid_q;
    assign bus.misalign_err = misalign_err_q;
    assign bus.retire_count = retire_count_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mem_wb_stage_if #(.DATA_W(32)) bus ();
    mem_wb_stage #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] mrd;
        logic [31:0] alu;
        logic [4:0]  code;
        logic        m2r;
        logic        rw;
        logic [4:0]  wreg;
        logic        chk_data;
        logic [31:0] e_data;
        logic [4:0]  e_reg;
        logic        e_we;
        logic        e_v;
        logic        e_err;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(logic v, logic [31:0] mrd, logic [31:0] alu, logic [4:0] code,
                                logic m2r, logic rw, logic [4:0] wreg, logic cd,
                                logic [31:0] ed, logic [4:0] er, logic ewe, logic ev,
                                logic eerr, logic [31:0] ecnt);
        vec_t t;
        t.valid = v; t.mrd = mrd; t.alu = alu; t.code = code; t.m2r = m2r; t.rw = rw;
        t.wreg = wreg; t.chk_data = cd; t.e_data = ed; t.e_reg = er; t.e_we = ewe;
        t.e_v = ev; t.e_err = eerr; t.e_cnt = ecnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] mrd, input logic [31:0] alu,
                         input logic [4:0] code, input logic m2r, input logic rw,
                         input logic [4:0] wreg);
        bus.valid_in = v; bus.mem_read_data = mrd; bus.alu_result = alu;
        bus.alu_code = code; bus.mem_to_reg_in = m2r; bus.reg_write_in = rw;
        bus.write_reg_in = wreg;
    endtask

    // advance one rising edge and sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] d, input logic [4:0] r,
                           input logic we, input logic v, input logic err, input logic [31:0] cnt);
        chk({tag, ".wb_data"}, bus.wb_data, d);
        chk({tag, ".wb_reg"}, {27'd0, bus.wb_reg}, {27'd0, r});
        chk({tag, ".wb_reg_write"}, {31'd0, bus.wb_reg_write}, {31'd0, we});
        chk({tag, ".valid_out"}, {31'd0, bus.valid_out}, {31'd0, v});
        chk({tag, ".misalign_err"}, {31'd0, bus.misalign_err}, {31'd0, err});
        chk({tag, ".retire_count"}, bus.retire_count, cnt);
    endtask

    localparam logic [4:0]  LB = 5'b01000;
    localparam logic [4:0]  LH = 5'b00111;
    localparam logic [4:0]  LW = 5'b00000;
    localparam logic [31:0] W  = 32'h80FF7F01;

    initial begin
        vecs[0] = mk(1, W, 32'h10, LB, 1, 1, 8, 1, 32'h00000001, 8, 1, 1, 0, 1);
        vecs[1] = mk(1, W, 32'h11, LB, 1, 1, 8, 1, 32'h0000007F, 8, 1, 1, 0, 2);
        vecs[2] = mk(1, W, 32'h12, LB, 1, 1, 8, 1, 32'hFFFFFFFF, 8, 1, 1, 0, 3);
        vecs[3] = mk(1, W, 32'h13, LB, 1, 1, 8, 1, 32'hFFFFFF80, 8, 1, 1, 0, 4);
        vecs[4] = mk(1, W, 32'h20, LH, 1, 1, 8, 1, 32'h00007F01, 8, 1, 1, 0, 5);
        vecs[5] = mk(1, W, 32'h22, LH, 1, 1, 8, 1, 32'hFFFF80FF, 8, 1, 1, 0, 6);
        // ALU path to r0: code ignored, no write
        vecs[6] = mk(1, W, 32'h1234, LH, 0, 1, 0, 1, 32'h00001234, 0, 0, 1, 0, 7);
        // bubble: data/reg don't-care, no count
        vecs[7] = mk(0, W, 32'h55, LW, 0, 1, 3, 0, 32'h0, 0, 0, 0, 0, 7);
        vecs[8] = mk(1, W, 32'h40, LW, 1, 1, 5, 1, W, 5, 1, 1, 0, 8);
        // misaligned lh: raw word, no write, sticky error
        vecs[9] = mk(1, W, 32'h21, LH, 1, 1, 8, 1, W, 8, 0, 1, 1, 9);

        bus.stall = 0; bus.flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // reset state before any clock edge
        #3;
        chk_all("reset0", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].mrd, vecs[i].alu, vecs[i].code,
                  vecs[i].m2r, vecs[i].rw, vecs[i].wreg);
            tick();
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d.wb_data", i), bus.wb_data, vecs[i].e_data);
                chk($sformatf("vec%0d.wb_reg", i), {27'd0, bus.wb_reg}, {27'd0, vecs[i].e_reg});
            end
            chk($sformatf("vec%0d.wb_reg_write", i), {31'd0, bus.wb_reg_write}, {31'd0, vecs[i].e_we});
            chk($sformatf("vec%0d.valid_out", i), {31'd0, bus.valid_out}, {31'd0, vecs[i].e_v});
            chk($sformatf("vec%0d.misalign_err", i), {31'd0, bus.misalign_err}, {31'd0, vecs[i].e_err});
            chk($sformatf("vec%0d.retire_count", i), bus.retire_count, vecs[i].e_cnt);
        end

        // misalign_err stays set through 10 bubbles
        drive(0, 0, 0, LW, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("sticky%0d.misalign_err", i), {31'd0, bus.misalign_err}, 32'd1);
            chk($sformatf("sticky%0d.retire_count", i), bus.retire_count, 32'd9);
        end

        // lw to r5, then 3 stalled cycles with changing inputs
        drive(1, 32'hCAFEF00D, 32'h100, LW, 1, 1, 5);
        tick();
        chk_all("lw5", 32'hCAFEF00D, 5, 1, 1, 1, 10);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h11223344 + i, 32'h1 + i, LB, 1, 1, 7);
            tick();
            chk_all($sformatf("stall%0d", i), 32'hCAFEF00D, 5, 1, 1, 1, 10);
        end
        // flush overrides stall
        bus.flush = 1;
        tick();
        chk_all("stallflush", 0, 0, 0, 0, 1, 10);

        // capture something nonzero, then reset mid-cycle
        bus.stall = 0; bus.flush = 0;
        drive(1, 32'hDEAD0004, 32'h104, LW, 1, 1, 5);
        tick();
        chk_all("prereset", 32'hDEAD0004, 5, 1, 1, 1, 11);
        #2;
        rst_n = 0;
        #1;
        chk_all("asyncreset", 0, 0, 0, 0, 0, 0);

        // first edge after release: flush with a misaligned lw -> no error
        bus.flush = 1;
        drive(1, 32'h12345678, 32'h201, LW, 1, 1, 6);
        @(negedge clk);
        rst_n = 1;
        tick();
        chk_all("flushmis", 0, 0, 0, 0, 0, 0);
        bus.flush = 0;
        drive(1, 32'h000000A5, 32'h300, LW, 1, 1, 9);
        tick();
        chk_all("postreset", 32'hA5, 9, 1, 1, 0, 1);

        // counter wrap: preload while stalled
        bus.stall = 1;
        force dut.retire_count_q = 32'hFFFFFFFF;
        tick();
        release dut.retire_count_q;
        #1;
        chk("preload.retire_count", bus.retire_count, 32'hFFFFFFFF);
        bus.stall = 0;
        drive(1, 32'h7, 32'h8, LW, 1, 1, 4);
        tick();
        chk("wrap.retire_count", bus.retire_count, 32'h0);
        chk("wrap.wb_data", bus.wb_data, 32'h7);
        drive(0, 32'h7, 32'h8, LW, 1, 1, 4);
        tick();
        chk("bubble.retire_count", bus.retire_count, 32'h0);
        chk("bubble.valid_out", {31'd0, bus.valid_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
